// File: rtl/idma_axis_write_if.sv
// Bundle of the iDMA AXI Stream write task: descriptor, completion, meta,
// AXI Stream manager and per-byte transport buffer channels.
interface idma_axis_write_if #(
  parameter int unsigned StrbWidth     = 16,
  parameter int unsigned NumBeatsWidth = 8
);
  localparam int unsigned OffsetWidth = $clog2(StrbWidth) + 1;

  typedef logic [7:0]           byte_t;
  typedef logic [StrbWidth-1:0] strb_t;

  typedef struct packed {
    byte_t [StrbWidth-1:0] data;
    strb_t                 strb;
    strb_t                 keep;
    logic                  last;
  } axis_t_t;

  typedef struct packed {
    axis_t_t t;
    logic    tvalid;
  } write_req_t;

  typedef struct packed {
    logic tready;
  } write_rsp_t;

  typedef struct packed {
    logic [OffsetWidth-1:0]   offset;
    logic [OffsetWidth-1:0]   tailer;
    logic [NumBeatsWidth-1:0] num_beats;
    logic                     is_single;
  } w_dp_req_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       user;
  } w_dp_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
  } write_meta_chan_t;

  // Every channel is valid/ready: a transfer happens in the cycle where both
  // are high; valid never waits on ready and the payload holds until the transfer.
  w_dp_req_t             w_dp_req_i;
  logic                  w_dp_req_valid_i;
  logic                  w_dp_req_ready_o;
  w_dp_rsp_t             w_dp_rsp_o;
  logic                  w_dp_rsp_valid_o;
  logic                  w_dp_rsp_ready_i;
  write_meta_chan_t      write_meta_req_i;
  logic                  write_meta_valid_i;
  logic                  write_meta_ready_o;
  write_req_t            write_req_o;
  write_rsp_t            write_rsp_i;
  byte_t [StrbWidth-1:0] buffer_out_i;
  strb_t                 buffer_out_valid_i;
  strb_t                 buffer_out_ready_o;
  logic                  w_chan_valid_o;
  logic                  w_chan_ready_o;

  modport master (
    output w_dp_req_i, w_dp_req_valid_i, w_dp_rsp_ready_i,
    output write_meta_req_i, write_meta_valid_i, write_rsp_i,
    output buffer_out_i, buffer_out_valid_i,
    input  w_dp_req_ready_o, w_dp_rsp_o, w_dp_rsp_valid_o,
    input  write_meta_ready_o, write_req_o, buffer_out_ready_o,
    input  w_chan_valid_o, w_chan_ready_o
  );

  modport slave (
    input  w_dp_req_i, w_dp_req_valid_i, w_dp_rsp_ready_i,
    input  write_meta_req_i, write_meta_valid_i, write_rsp_i,
    input  buffer_out_i, buffer_out_valid_i,
    output w_dp_req_ready_o, w_dp_rsp_o, w_dp_rsp_valid_o,
    output write_meta_ready_o, write_req_o, buffer_out_ready_o,
    output w_chan_valid_o, w_chan_ready_o
  );
endinterface

// File: rtl/idma_axis_write.sv
// iDMA write task for an AXI Stream destination: drains the per-byte buffer
// into masked AXI Stream beats with tlast and reports completion per descriptor.
module idma_axis_write #(
  parameter int unsigned StrbWidth     = 16,
  parameter int unsigned NumBeatsWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  idma_axis_write_if.slave    bus,
  output logic [1:0]          dbg_state_o
);
  localparam int unsigned OffsetWidth = $clog2(StrbWidth) + 1;

  typedef logic [StrbWidth-1:0] strb_t;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [NumBeatsWidth-1:0] beat_cnt_q;
  logic [OffsetWidth-1:0]   offset_q, tailer_q, tail_shift;
  logic                     single_q, first_q;
  strb_t                    first_mask, last_mask, mask;
  logic                     last_beat, tvalid, tready, fire;
  logic                     accept, req_ready, rsp_valid;
  logic                     unused_meta;

  assign first_mask = {StrbWidth{1'b1}} << offset_q;
  assign tail_shift = OffsetWidth'(StrbWidth) - tailer_q;
  // A tailer of zero means the last beat is full.
  assign last_mask  = (tailer_q != '0) ? ({StrbWidth{1'b1}} >> tail_shift)
                                       : {StrbWidth{1'b1}};
  assign last_beat  = (beat_cnt_q == '0) || single_q;
  assign mask       = (first_q ? first_mask : {StrbWidth{1'b1}}) &
                      (last_beat ? last_mask : {StrbWidth{1'b1}});

  assign tready = bus.write_rsp_i.tready;
  // Bytes outside the mask are don't-care; tvalid never looks at tready.
  assign tvalid = (state_q == STREAM) && (&(bus.buffer_out_valid_i | ~mask));
  assign fire   = tvalid && tready;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.w_dp_req_valid_i) begin
          accept  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (fire && (beat_cnt_q == '0)) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = bus.w_dp_rsp_ready_i;
        if (bus.w_dp_rsp_ready_i) begin
          if (bus.w_dp_req_valid_i) begin
            accept  = 1'b1;
            state_d = STREAM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      offset_q   <= '0;
      tailer_q   <= '0;
      single_q   <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        offset_q   <= bus.w_dp_req_i.offset;
        tailer_q   <= bus.w_dp_req_i.tailer;
        single_q   <= bus.w_dp_req_i.is_single;
        beat_cnt_q <= bus.w_dp_req_i.num_beats;
        first_q    <= 1'b1;
      end else if (fire) begin
        first_q <= 1'b0;
        if (beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - 1'b1;
      end
    end
  end

  assign bus.w_dp_req_ready_o   = req_ready;
  assign bus.w_dp_rsp_valid_o   = rsp_valid;
  assign bus.w_dp_rsp_o         = '0;
  assign bus.write_meta_ready_o = 1'b1;
  assign bus.write_req_o        = {bus.buffer_out_i, mask, mask, last_beat, tvalid};
  assign bus.buffer_out_ready_o = fire ? mask : '0;
  assign bus.w_chan_valid_o     = tvalid;
  assign bus.w_chan_ready_o     = tready;
  assign dbg_state_o            = state_q;

  // AXI Stream has no address phase, so the meta payload is accepted and dropped.
  assign unused_meta = ^{bus.write_meta_req_i, bus.write_meta_valid_i};
endmodule

// File: tb/tb_idma_axis_write.sv
// Randomized bench for idma_axis_write: a queue-based beat model per descriptor,
// a per-lane byte source and a per-cycle compare of every output.
module tb_idma_axis_write;
  localparam int SW  = 16;
  localparam int NBW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  idma_axis_write_if #(.StrbWidth(SW), .NumBeatsWidth(NBW)) bus ();

  idma_axis_write #(.StrbWidth(SW), .NumBeatsWidth(NBW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    int off;
    int tail;
    int nb;
    bit single;
  } desc_t;

  // Scoreboard
  logic [SW-1:0] exp_q[$];
  bit            exp_last_q[$];
  bit            pending_rsp;
  logic [SW-1:0] tmp_s[$];
  bit            tmp_l[$];
  int            errors = 0;
  int            checks = 0;

  // Byte source: one head byte per lane, sticky once shown valid.
  logic [7:0] lane_head[SW];
  bit         lane_vis[SW];

  desc_t desc_q[$];
  bit    req_taken;
  bit    rand_desc;
  int    p_tready, p_vis, p_rsp, p_desc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beats of one descriptor: first beat keeps bytes >= offset, last beat keeps
  // the low 'tailer' bytes (all when tailer is zero).
  task automatic model_beats(input desc_t d);
    logic [SW-1:0] m;
    int n;
    tmp_s.delete();
    tmp_l.delete();
    n = d.single ? 0 : d.nb;
    for (int b = 0; b <= n; b++) begin
      m = '1;
      if (b == 0) for (int i = 0; i < d.off; i++) m[i] = 1'b0;
      if (b == n && d.tail != 0) for (int i = d.tail; i < SW; i++) m[i] = 1'b0;
      tmp_s.push_back(m);
      tmp_l.push_back(b == n);
    end
  endtask

  task automatic drive_desc(input desc_t d);
    bus.w_dp_req_i.offset    = 5'(d.off);
    bus.w_dp_req_i.tailer    = 5'(d.tail);
    bus.w_dp_req_i.num_beats = 8'(d.nb);
    bus.w_dp_req_i.is_single = d.single;
    bus.w_dp_req_valid_i     = 1'b1;
  endtask

  task automatic cycle();
    desc_t         d;
    logic [SW-1:0] m;
    logic [SW-1:0][7:0] exp_data;
    bit busy, e_req_ready, e_tvalid, fire, rsp_hs, accept;
    @(posedge clk);
    #1;
    bus.write_rsp_i.tready = ($urandom_range(0, 99) < p_tready);
    bus.w_dp_rsp_ready_i   = ($urandom_range(0, 99) < p_rsp);
    bus.write_meta_valid_i = $urandom_range(0, 1) == 1;
    bus.write_meta_req_i.addr = $urandom;
    if (req_taken) begin
      bus.w_dp_req_valid_i = 1'b0;
      req_taken = 1'b0;
    end
    if (!bus.w_dp_req_valid_i) begin
      if (desc_q.size() != 0) begin
        drive_desc(desc_q.pop_front());
      end else if (rand_desc && $urandom_range(0, 99) < p_desc) begin
        d.off    = $urandom_range(0, SW - 1);
        d.tail   = $urandom_range(0, SW - 1);
        d.single = $urandom_range(0, 3) == 0;
        d.nb     = d.single ? 0 : $urandom_range(0, 5);
        drive_desc(d);
      end
    end
    for (int i = 0; i < SW; i++) begin
      if (!lane_vis[i] && $urandom_range(0, 99) < p_vis) lane_vis[i] = 1'b1;
      bus.buffer_out_valid_i[i] = lane_vis[i];
      bus.buffer_out_i[i]       = lane_head[i];
      exp_data[i]               = lane_head[i];
    end
    #3;
    busy        = (exp_q.size() != 0) || pending_rsp;
    e_req_ready = !busy || (pending_rsp && bus.w_dp_rsp_ready_i);
    e_tvalid    = 1'b0;
    m           = '0;
    if (exp_q.size() != 0) begin
      m = exp_q[0];
      e_tvalid = 1'b1;
      for (int i = 0; i < SW; i++) if (m[i] && !lane_vis[i]) e_tvalid = 1'b0;
    end
    fire = e_tvalid && bus.write_rsp_i.tready;
    chk("tvalid", bus.write_req_o.tvalid, e_tvalid);
    chk("req_ready", bus.w_dp_req_ready_o, e_req_ready);
    chk("rsp_valid", bus.w_dp_rsp_valid_o, pending_rsp);
    chk("meta_ready", bus.write_meta_ready_o, 1'b1);
    chk("w_chan_valid", bus.w_chan_valid_o, e_tvalid);
    chk("w_chan_ready", bus.w_chan_ready_o, bus.write_rsp_i.tready);
    chk("buf_ready", bus.buffer_out_ready_o, fire ? m : '0);
    if (e_tvalid) begin
      chk("strb", bus.write_req_o.t.strb, m);
      chk("keep", bus.write_req_o.t.keep, m);
      chk("tlast", bus.write_req_o.t.last, exp_last_q[0]);
      chk("tdata", bus.write_req_o.t.data, exp_data);
    end
    if (pending_rsp) chk("rsp_payload", bus.w_dp_rsp_o, '0);
    rsp_hs = pending_rsp && bus.w_dp_rsp_ready_i;
    accept = bus.w_dp_req_valid_i && e_req_ready;
    if (fire) begin
      for (int i = 0; i < SW; i++) if (m[i]) begin
        lane_head[i] = 8'($urandom);
        lane_vis[i]  = 1'b0;
      end
      void'(exp_q.pop_front());
      if (exp_last_q.pop_front()) pending_rsp = 1'b1;
    end
    if (rsp_hs) pending_rsp = 1'b0;
    if (accept) begin
      d.off    = int'(bus.w_dp_req_i.offset);
      d.tail   = int'(bus.w_dp_req_i.tailer);
      d.nb     = int'(bus.w_dp_req_i.num_beats);
      d.single = bus.w_dp_req_i.is_single;
      model_beats(d);
      foreach (tmp_s[k]) begin
        exp_q.push_back(tmp_s[k]);
        exp_last_q.push_back(tmp_l[k]);
      end
      req_taken = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic knobs(input int t, input int v, input int r);
    p_tready = t;
    p_vis    = v;
    p_rsp    = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, bus.write_req_o.tvalid, 1'b0);
    chk({tag, "_req_ready"}, bus.w_dp_req_ready_o, 1'b1);
    chk({tag, "_rsp_valid"}, bus.w_dp_rsp_valid_o, 1'b0);
    chk({tag, "_buf_ready"}, bus.buffer_out_ready_o, '0);
    chk({tag, "_meta_ready"}, bus.write_meta_ready_o, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.w_dp_req_valid_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    exp_last_q.delete();
    pending_rsp = 1'b0;
    req_taken   = 1'b0;
    rst = 1'b0;
  endtask

  function automatic desc_t mk(input int off, input int tail, input int nb, input bit single);
    desc_t d;
    d.off = off; d.tail = tail; d.nb = nb; d.single = single;
    return d;
  endfunction

  initial begin
    rst = 1'b1;
    bus.w_dp_req_i         = '0;
    bus.w_dp_req_valid_i   = 1'b0;
    bus.w_dp_rsp_ready_i   = 1'b0;
    bus.write_meta_req_i   = '0;
    bus.write_meta_valid_i = 1'b0;
    bus.write_rsp_i        = '0;
    bus.buffer_out_i       = '0;
    bus.buffer_out_valid_i = '0;
    for (int i = 0; i < SW; i++) begin
      lane_head[i] = 8'($urandom);
      lane_vis[i]  = 1'b0;
    end
    pending_rsp = 1'b0;
    req_taken   = 1'b0;
    rand_desc   = 1'b0;
    p_desc      = 40;
    knobs(100, 100, 100);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Pin the model against hand-computed masks.
    model_beats(mk(3, 5, 2, 1'b0));
    chk("model_len3", tmp_s.size(), 3);
    chk("model_b0", tmp_s[0], 16'hFFF8);
    chk("model_b1", tmp_s[1], 16'hFFFF);
    chk("model_b2", tmp_s[2], 16'h001F);
    chk("model_last", {tmp_l[0], tmp_l[1], tmp_l[2]}, 3'b001);
    model_beats(mk(2, 10, 0, 1'b1));
    chk("model_single", tmp_s[0], 16'h03FC);
    chk("model_single_last", tmp_l[0], 1'b1);

    // Directed: 3-beat burst then a single beat, full-rate.
    desc_q.push_back(mk(3, 5, 2, 1'b0));
    desc_q.push_back(mk(2, 10, 0, 1'b1));
    run(12);

    // tready held low mid-burst.
    desc_q.push_back(mk(0, 0, 7, 1'b0));
    run(4);
    knobs(0, 100, 100);
    run(5);
    knobs(100, 100, 100);
    run(10);

    // Completion held off while the next descriptor waits.
    knobs(100, 100, 0);
    desc_q.push_back(mk(1, 4, 1, 1'b0));
    desc_q.push_back(mk(5, 0, 0, 1'b0));
    run(8);
    knobs(100, 100, 100);
    run(8);

    // Sparse buffer validity exercises masked-out invalid bytes.
    knobs(100, 40, 100);
    desc_q.push_back(mk(3, 0, 3, 1'b0));
    run(30);

    // Random traffic.
    rand_desc = 1'b1;
    knobs(70, 70, 70);
    run(2000);

    // Reset mid-stream, then a fresh transfer.
    rand_desc = 1'b0;
    knobs(100, 100, 100);
    run(20);
    desc_q.push_back(mk(0, 0, 20, 1'b0));
    run(5);
    pulse_reset();
    desc_q.push_back(mk(3, 5, 2, 1'b0));
    run(15);

    // Random traffic under heavier back-pressure.
    rand_desc = 1'b1;
    knobs(30, 50, 30);
    run(1500);

    // Drain: every accepted transfer must have finished and been acknowledged.
    rand_desc = 1'b0;
    knobs(100, 100, 100);
    run(200);
    chk("drain_beats", exp_q.size(), 0);
    chk("drain_rsp", pending_rsp, 1'b0);
    chk("drain_desc", bus.w_dp_req_valid_i && !req_taken, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
